// File: rtl/ifu.sv
// Instruction fetch unit: PC register, loadable instruction memory and a
// registered fetch stage with stall, redirect and a sticky halt.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   stall               - hold fetch state and outputs
//   redirect            - load redirect_pc as the next fetch address
//   redirect_pc         - byte address of the redirect target
//   im_we/im_waddr/im_wdata - instruction memory program-load port
//   instr, pc           - fetched word and its byte address
//   op/funct/rs/rt/rd/imm16 - field slices of instr
//   instr_valid         - instr/pc/fields hold a real fetched instruction
//   halt                - sticky; fetch stopped until reset
//   err_misalign        - sticky; halt caused by a misaligned redirect
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned AW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          im_we,
   input  logic [AW-1:0] im_waddr,
   input  logic [31:0]   im_wdata,
   output logic [31:0]   instr,
   output logic [31:0]   pc,
   output logic [5:0]    op,
   output logic [5:0]    funct,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [15:0]   imm16,
   output logic          instr_valid,
   output logic          halt,
   output logic          err_misalign
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [31:0] mem_q [DEPTH];

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        halt_q, halt_d;
   logic        err_q, err_d;

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic [31:0]   rd_word;

   // Offset from the image base; the upper bits must be zero for the
   // word index to land inside the memory.
   assign off = fetch_pc_q - RESET_PC;
   assign idx = off[AW+1:2];

   // fetch_pc is always word aligned (misaligned redirects halt instead
   // of loading), so the low-bit test only guards an impossible state.
   assign in_range = (fetch_pc_q >= RESET_PC) &&
                     (off[31:AW+2] == '0) &&
                     (off[1:0] == 2'b00);

   // Combinational read of the pre-edge contents gives read-before-write
   // when a program-load write hits the word being fetched.
   assign rd_word = mem_q[idx];

   always_ff @(posedge clk) begin
      if (im_we) begin
         mem_q[im_waddr] <= im_wdata;
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      halt_d     = halt_q;
      err_d      = err_q;
      if (halt_q) begin
         valid_d = 1'b0;
      end else if (redirect) begin
         valid_d = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            halt_d = 1'b1;
            err_d  = 1'b1;
         end else begin
            // The sequential fetch in flight is dropped: one bubble.
            fetch_pc_d = redirect_pc;
         end
      end else if (stall) begin
         fetch_pc_d = fetch_pc_q;
      end else if (in_range) begin
         instr_d    = rd_word;
         pc_d       = fetch_pc_q;
         valid_d    = 1'b1;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
         halt_d  = 1'b1;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         instr_q    <= '0;
         pc_q       <= '0;
         valid_q    <= 1'b0;
         halt_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         halt_q     <= halt_d;
         err_q      <= err_d;
      end
   end

   assign instr        = instr_q;
   assign pc           = pc_q;
   assign instr_valid  = valid_q;
   assign halt         = halt_q;
   assign err_misalign = err_q;

   assign op    = instr_q[31:26];
   assign rs    = instr_q[25:21];
   assign rt    = instr_q[20:16];
   assign rd    = instr_q[15:11];
   assign funct = instr_q[5:0];
   assign imm16 = instr_q[15:0];

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a full-size instance for fetch/stall/redirect/halt
// and a 4-word instance for the end-of-memory halt.
module tb_ifu;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Main instance (AW = 10)
   logic        reset, stall, redirect, im_we;
   logic [31:0] redirect_pc, im_wdata;
   logic [9:0]  im_waddr;
   logic [31:0] instr, pc;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic        instr_valid, halt, err_misalign;

   // Small instance (AW = 2)
   logic        s_reset, s_stall, s_redirect, s_im_we;
   logic [31:0] s_redirect_pc, s_im_wdata;
   logic [1:0]  s_im_waddr;
   logic [31:0] s_instr, s_pc;
   logic [5:0]  s_op, s_funct;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic [15:0] s_imm16;
   logic        s_valid, s_halt, s_err;

   ifu #(.RESET_PC(32'h0000_3000), .AW(10)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .im_we(im_we), .im_waddr(im_waddr),
      .im_wdata(im_wdata), .instr(instr), .pc(pc), .op(op), .funct(funct),
      .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .instr_valid(instr_valid),
      .halt(halt), .err_misalign(err_misalign)
   );

   ifu #(.RESET_PC(32'h0000_3000), .AW(2)) u_small (
      .clk(clk), .reset(s_reset), .stall(s_stall), .redirect(s_redirect),
      .redirect_pc(s_redirect_pc), .im_we(s_im_we), .im_waddr(s_im_waddr),
      .im_wdata(s_im_wdata), .instr(s_instr), .pc(s_pc), .op(s_op),
      .funct(s_funct), .rs(s_rs), .rt(s_rt), .rd(s_rd), .imm16(s_imm16),
      .instr_valid(s_valid), .halt(s_halt), .err_misalign(s_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] e_pc,
                          input logic [31:0] e_instr, input logic e_v);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".instr"}, instr, e_instr);
      chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, e_v});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      im_we = 1'b0; im_waddr = '0; im_wdata = '0;
      s_reset = 1'b1; s_stall = 1'b0; s_redirect = 1'b0; s_redirect_pc = '0;
      s_im_we = 1'b0; s_im_waddr = '0; s_im_wdata = '0;

      // Program load during reset
      im_we = 1'b1;
      im_waddr = 10'd0; im_wdata = 32'h0022_1820; step();
      im_waddr = 10'd1; im_wdata = 32'h3401_0005; step();
      im_waddr = 10'd2; im_wdata = 32'h3C01_ABCD; step();
      im_waddr = 10'd3; im_wdata = 32'h0000_0000; step();
      im_we = 1'b0;
      chk_out("rst", 32'h0, 32'h0, 1'b0);
      chk("rst.halt", {31'd0, halt}, 32'd0);
      chk("rst.err", {31'd0, err_misalign}, 32'd0);

      // Sequential fetch
      reset = 1'b0;
      step();
      chk_out("f0", 32'h3000, 32'h0022_1820, 1'b1);
      chk("f0.op", {26'd0, op}, 32'h0);
      chk("f0.funct", {26'd0, funct}, 32'h20);
      chk("f0.rs", {27'd0, rs}, 32'd1);
      chk("f0.rt", {27'd0, rt}, 32'd2);
      chk("f0.rd", {27'd0, rd}, 32'd3);
      chk("f0.imm", {16'd0, imm16}, 32'h1820);
      step();
      chk_out("f1", 32'h3004, 32'h3401_0005, 1'b1);

      // Stall three cycles at 0x3004
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall", 32'h3004, 32'h3401_0005, 1'b1);
      end
      stall = 1'b0;
      step();
      chk_out("f2", 32'h3008, 32'h3C01_ABCD, 1'b1);
      chk("f2.op", {26'd0, op}, 32'h0F);
      chk("f2.rt", {27'd0, rt}, 32'd1);
      chk("f2.imm", {16'd0, imm16}, 32'hABCD);
      step();
      chk_out("f3", 32'h300C, 32'h0, 1'b1);

      // Redirect wins over stall
      redirect = 1'b1; redirect_pc = 32'h3000; stall = 1'b1;
      step();
      chk("rdr.bubble", {31'd0, instr_valid}, 32'd0);
      redirect = 1'b0; stall = 1'b0;
      step();
      chk_out("rdr.tgt", 32'h3000, 32'h0022_1820, 1'b1);

      // Write/fetch collision on word 1
      im_we = 1'b1; im_waddr = 10'd1; im_wdata = 32'hDEAD_BEEF;
      step();
      im_we = 1'b0;
      chk_out("coll.old", 32'h3004, 32'h3401_0005, 1'b1);
      step();
      chk_out("coll.next", 32'h3008, 32'h3C01_ABCD, 1'b1);
      redirect = 1'b1; redirect_pc = 32'h3004;
      step();
      redirect = 1'b0;
      chk("coll.bubble", {31'd0, instr_valid}, 32'd0);
      step();
      chk_out("coll.new", 32'h3004, 32'hDEAD_BEEF, 1'b1);

      // Misaligned redirect
      redirect = 1'b1; redirect_pc = 32'h3002;
      step();
      redirect = 1'b0;
      chk("mis.halt", {31'd0, halt}, 32'd1);
      chk("mis.err", {31'd0, err_misalign}, 32'd1);
      chk("mis.valid", {31'd0, instr_valid}, 32'd0);
      im_we = 1'b1; im_waddr = 10'd2; im_wdata = 32'h1234_5678;
      step();
      im_we = 1'b0;
      step();
      chk("mis.halt2", {31'd0, halt}, 32'd1);
      chk("mis.err2", {31'd0, err_misalign}, 32'd1);
      chk("mis.valid2", {31'd0, instr_valid}, 32'd0);
      chk("mis.pc", pc, 32'h3004);

      // Reset clears the sticky flags; memory survives
      reset = 1'b1;
      step();
      chk("rst2.halt", {31'd0, halt}, 32'd0);
      chk("rst2.err", {31'd0, err_misalign}, 32'd0);
      reset = 1'b0;
      step();
      chk_out("rs0", 32'h3000, 32'h0022_1820, 1'b1);
      step();
      chk_out("rs1", 32'h3004, 32'hDEAD_BEEF, 1'b1);
      step();
      chk_out("rs2", 32'h3008, 32'h1234_5678, 1'b1);

      // Redirect below the image base halts on the next fetch
      redirect = 1'b1; redirect_pc = 32'h2FFC;
      step();
      redirect = 1'b0;
      chk("low.bubble", {31'd0, instr_valid}, 32'd0);
      chk("low.nohalt", {31'd0, halt}, 32'd0);
      step();
      chk("low.halt", {31'd0, halt}, 32'd1);
      chk("low.err", {31'd0, err_misalign}, 32'd0);
      chk("low.valid", {31'd0, instr_valid}, 32'd0);

      // Small instance: run off the end of a 4-word memory
      s_im_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_im_waddr = 2'(i);
         s_im_wdata = 32'h1111_1111 * (i + 1);
         step();
      end
      s_im_we = 1'b0;
      s_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("sm.pc", s_pc, 32'h3000 + 32'(4 * i));
         chk("sm.instr", s_instr, 32'h1111_1111 * (i + 1));
         chk("sm.valid", {31'd0, s_valid}, 32'd1);
         chk("sm.nohalt", {31'd0, s_halt}, 32'd0);
      end
      step();
      chk("sm.halt", {31'd0, s_halt}, 32'd1);
      chk("sm.err", {31'd0, s_err}, 32'd0);
      chk("sm.valid_end", {31'd0, s_valid}, 32'd0);
      chk("sm.pc_hold", s_pc, 32'h300C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle MIPS core: holds the PC, owns a loadable instruction memory and presents each fetched instruction word, pre-split into `op`/`funct`/register/immediate fields, to the control decoder and datapath. It is the producer side of the `op`/`funct` interface that the control decoder consumes. It adds a registered fetch stage with stall, redirect (branch/jump target) and a sticky halt on out-of-range or misaligned PCs.

## Interface
- `RESET_PC`, 32'h0000_3000, PC of the first fetched instruction after reset.
- `AW`, 10, instruction memory word-address width; depth = 2^AW words.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `stall` in 1: hold fetch state and outputs this cycle.
- `redirect` in 1: replace next fetch PC with `redirect_pc`.
- `redirect_pc` in 32: byte address of redirect target.
- `im_we` in 1: instruction memory write enable (program load).
- `im_waddr` in AW: word index written.
- `im_wdata` in 32: word written.
- `instr` out 32: fetched instruction word.
- `pc` out 32: byte address of `instr`.
- `op` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `rs` / `rt` / `rd` out 5 each: `instr[25:21]` / `[20:16]` / `[15:11]`.
- `imm16` out 16: `instr[15:0]`.
- `instr_valid` out 1: `instr`/`pc`/fields are a real fetched instruction.
- `halt` out 1: sticky; fetch stopped.
- `err_misalign` out 1: sticky; halt caused by a redirect target with `redirect_pc[1:0] != 0`.

## Operation
- State: `fetch_pc` (32), output registers `instr`, `pc`, `instr_valid`, `halt`, `err_misalign`. Fields are combinational slices of the `instr` register.
- Index: `idx = (fetch_pc - RESET_PC) >> 2`. In range iff `fetch_pc >= RESET_PC` and `(fetch_pc - RESET_PC) >> 2 < 2^AW`.
- Priority per cycle (highest first): `reset`, `halt`, `redirect`, `stall`, normal fetch.
- Reset: `fetch_pc <= RESET_PC`; `instr <= 0`; `pc <= 0`; `instr_valid`, `halt`, `err_misalign` <= 0. Memory contents are not cleared, so a loaded program survives reset.
- Halted: all fetch state frozen; `instr_valid <= 0`. Only reset clears it.
- Redirect:
  - If `redirect_pc[1:0] != 0`: `halt <= 1`, `err_misalign <= 1`, `instr_valid <= 0`.
  - Otherwise: `fetch_pc <= redirect_pc`, `instr_valid <= 0` (one-cycle bubble; the in-flight sequential fetch is squashed).
  - Redirect overrides `stall` in the same cycle.
- Stall (no redirect): `fetch_pc`, `instr`, `pc`, `instr_valid` all hold.
- Normal fetch:
  - If in range: `instr <= mem[idx]`, `pc <= fetch_pc`, `instr_valid <= 1`, `fetch_pc <= fetch_pc + 4`.
  - If out of range: `halt <= 1`, `instr_valid <= 0`, `err_misalign` unchanged (0).
- Memory write: when `im_we`, `mem[im_waddr] <= im_wdata`. Writes are accepted in every state, including reset, halt and stall.
- Write/fetch collision: if the same word is written and fetched in the same cycle, `instr` receives the old contents (read-before-write).
- Wrap: `fetch_pc + 4` is 32-bit modulo. Any wrap past 0xFFFF_FFFC lands below `RESET_PC` and halts on the next fetch.

## Timing
- Fetch latency: one cycle. The word at `fetch_pc` appears on `instr` the cycle after the fetch edge.
- After reset deasserts: the first edge loads `mem[0]` with `pc = RESET_PC`. `instr_valid` is 1 from that edge onward.
- Throughput: one instruction per cycle without stall or redirect.
- Redirect costs exactly one invalid cycle. The target instruction is valid on the second edge after `redirect` is sampled.
- Halt: `halt` rises on the edge that detects the condition, in the same cycle `instr_valid` falls. It stays high until reset.
- `reset` asserted mid-run: takes effect on that edge regardless of `stall`, `redirect` or `halt`.

## Test plan
- Load mem[0..3] = 0x00221820, 0x34010005, 0x3C01ABCD, 0x00000000; reset; run with no stall -> `pc` = 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles with `instr_valid` = 1. First word shows `op` = 0, `funct` = 0x20, `rs` = 1, `rt` = 2, `rd` = 3.
- Assert `stall` for 3 cycles at `pc` = 0x3004 -> outputs held at 0x3004 / 0x34010005 for all 3 cycles; 0x3008 follows the cycle after release.
- `redirect` = 1, `redirect_pc` = 0x3000 while `stall` = 1 -> next cycle `instr_valid` = 0; cycle after, `pc` = 0x3000 with `instr` = mem[0].
- `redirect_pc` = 0x3002 -> `halt` = 1 and `err_misalign` = 1, `instr_valid` = 0; both stay set until reset, which clears them and restarts at 0x3000.
- With AW = 2, run sequentially -> after `pc` = 0x300C, `halt` = 1 with `err_misalign` = 0. Also `redirect_pc` = 0x2FFC -> `halt` = 1.
- Write `mem[1]` = 0xDEADBEEF in the same cycle index 1 is fetched -> `instr` = old word. A later redirect to 0x3004 fetches 0xDEADBEEF.
